// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port between writeback and the mul/div unit and tracks pending mul/div writes.
// Grant is combinational (0 cycles); scoreboard updates next edge; mul/div is refused at most MAX_WAIT cycles.
module rf_wr_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_num,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        mc_valid,
    input  logic [4:0]  mc_num,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_num,
    output logic        iss_ready,
    input  logic [4:0]  rd0_num,
    input  logic [4:0]  rd1_num,
    output logic        rd0_busy,
    output logic        rd1_busy,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_num,
    output logic [31:0] rf_wr_data
);

    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

    // Bit 0 is never set, so r0 always reads as not pending.
    logic [31:0]   busy_q, busy_d;
    logic [AW-1:0] age_q, age_d;
    logic          wb_req;
    logic          mc_win;

    always_comb begin
        wb_req    = wb_valid && (wb_num != 5'd0);
        mc_win    = mc_valid && (!wb_req || (age_q == AGE_MAX));
        mc_ready  = reset_n && mc_win;
        wb_stall  = reset_n && wb_req && mc_win;
        iss_ready = reset_n && !busy_q[iss_num];
        rd0_busy  = reset_n && busy_q[rd0_num];
        rd1_busy  = reset_n && busy_q[rd1_num];
        if (mc_win) begin
            rf_wr_num  = mc_num;
            rf_wr_data = mc_data;
            rf_wr_en   = reset_n && (mc_num != 5'd0);
        end else begin
            rf_wr_num  = wb_num;
            rf_wr_data = wb_data;
            rf_wr_en   = reset_n && wb_req;
        end
    end

    always_comb begin
        age_d = '0;
        if (mc_valid && !mc_ready) begin
            age_d = (age_q == AGE_MAX) ? age_q : age_q + AW'(1);
        end
        busy_d = busy_q;
        if (mc_ready && (mc_num != 5'd0)) begin
            busy_d[mc_num] = 1'b0;
        end
        // iss_ready is low for a busy register, so this never collides with the clear above.
        if (iss_valid && iss_ready && (iss_num != 5'd0)) begin
            busy_d[iss_num] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            age_q  <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: expected port writes are queued as stimulus is driven and popped at the sampling edge.
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid, mc_valid, iss_valid;
    logic [4:0]  wb_num, mc_num, iss_num, rd0_num, rd1_num;
    logic [31:0] wb_data, mc_data;
    logic        wb_stall, mc_ready, iss_ready, rd0_busy, rd1_busy;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_num;
    logic [31:0] rf_wr_data;

    typedef struct {
        logic        en;
        logic [4:0]  num;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  vec = 0;
    int  err = 0;

    rf_wr_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data), .wb_stall(wb_stall),
        .mc_valid(mc_valid), .mc_num(mc_num), .mc_data(mc_data), .mc_ready(mc_ready),
        .iss_valid(iss_valid), .iss_num(iss_num), .iss_ready(iss_ready),
        .rd0_num(rd0_num), .rd1_num(rd1_num), .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
        .rf_wr_en(rf_wr_en), .rf_wr_num(rf_wr_num), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        wb_valid = 0; wb_num = 0; wb_data = 0;
        mc_valid = 0; mc_num = 0; mc_data = 0;
        iss_valid = 0; iss_num = 0;
        rd0_num = 0; rd1_num = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic en, input logic [4:0] num, input logic [31:0] data);
        wr_t w;
        w.en = en; w.num = num; w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        reset_n = 0;
        wb_valid = 1; wb_num = 5; wb_data = 32'h1;
        mc_valid = 1; mc_num = 6; mc_data = 32'h2;
        iss_valid = 1; iss_num = 8; rd0_num = 8; rd1_num = 6;
        repeat (2) begin
            @(negedge clk);
            vec++;
            if ({rf_wr_en, mc_ready, iss_ready, wb_stall, rd0_busy, rd1_busy} !== 6'b0) begin
                err++;
                $display("FAIL reset_outputs: got en/mcr/issr/stall/b0/b1=%b required 000000",
                         {rf_wr_en, mc_ready, iss_ready, wb_stall, rd0_busy, rd1_busy});
            end
        end
        next_cyc();
        idle_inputs();
        rd0_num = 8;
        wb_valid = 1; wb_num = 5; wb_data = 32'h1234;
        reset_n = 1;
        push_wr(1, 5, 32'h1234);
        @(negedge clk);
        e = exp_q.pop_front();
        vec++;
        if (rf_wr_en !== e.en || rf_wr_num !== e.num || rf_wr_data !== e.data || wb_stall !== 1'b0) begin
            err++;
            $display("FAIL release_wb: got en=%b num=%0d data=%h stall=%b required en=1 num=%0d data=%h stall=0",
                     rf_wr_en, rf_wr_num, rf_wr_data, wb_stall, e.num, e.data);
        end
        vec++;
        if (rd0_busy !== 1'b0) begin
            err++;
            $display("FAIL reset_no_issue: rd0_busy(r8) got %b required 0", rd0_busy);
        end
    endtask

    task automatic test_scoreboard();
        next_cyc();
        idle_inputs();
        iss_valid = 1; iss_num = 7; rd0_num = 7;
        push_wr(0, 0, 0);
        @(negedge clk);
        e = exp_q.pop_front();
        vec++;
        if (iss_ready !== 1'b1 || rd0_busy !== 1'b0 || rf_wr_en !== e.en) begin
            err++;
            $display("FAIL sb_issue: got iss_ready=%b rd0_busy=%b en=%b required 1 0 0", iss_ready, rd0_busy, rf_wr_en);
        end
        next_cyc();
        vec++;
        if (iss_ready !== 1'b0 || rd0_busy !== 1'b1) begin
            err++;
            $display("FAIL sb_reissue: got iss_ready=%b rd0_busy=%b required 0 1", iss_ready, rd0_busy);
        end
        next_cyc();
        iss_valid = 0;
        mc_valid = 1; mc_num = 7; mc_data = 32'hCAFE;
        push_wr(1, 7, 32'hCAFE);
        @(negedge clk);
        e = exp_q.pop_front();
        vec++;
        if (rf_wr_en !== e.en || rf_wr_num !== e.num || rf_wr_data !== e.data || mc_ready !== 1'b1 || rd0_busy !== 1'b1) begin
            err++;
            $display("FAIL sb_result: got en=%b num=%0d data=%h mc_ready=%b rd0_busy=%b required 1 %0d %h 1 1",
                     rf_wr_en, rf_wr_num, rf_wr_data, mc_ready, rd0_busy, e.num, e.data);
        end
        next_cyc();
        mc_valid = 0;
        vec++;
        if (rd0_busy !== 1'b0) begin
            err++;
            $display("FAIL sb_cleared: rd0_busy got %b required 0", rd0_busy);
        end
    endtask

    task automatic test_starvation();
        logic grant;
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            wb_valid = 1; wb_num = 10; wb_data = 32'h100 + i;
            mc_valid = 1; mc_num = 11; mc_data = 32'hBEEF;
            grant = (i == 4) || (i == 9);
            if (grant) push_wr(1, 11, 32'hBEEF);
            else       push_wr(1, 10, 32'h100 + i);
            @(negedge clk);
            e = exp_q.pop_front();
            vec++;
            if (rf_wr_en !== e.en || rf_wr_num !== e.num || rf_wr_data !== e.data ||
                mc_ready !== grant || wb_stall !== grant) begin
                err++;
                $display("FAIL starve_cycle%0d: got en=%b num=%0d data=%h mc_ready=%b stall=%b required 1 %0d %h %b %b",
                         i, rf_wr_en, rf_wr_num, rf_wr_data, mc_ready, wb_stall, e.num, e.data, grant, grant);
            end
        end
    endtask

    task automatic test_r0();
        next_cyc();
        idle_inputs();
        wb_valid = 1; wb_num = 0; wb_data = 32'hDEAD;
        mc_valid = 1; mc_num = 13; mc_data = 32'h55;
        push_wr(1, 13, 32'h55);
        @(negedge clk);
        e = exp_q.pop_front();
        vec++;
        if (rf_wr_en !== e.en || rf_wr_num !== e.num || rf_wr_data !== e.data || mc_ready !== 1'b1 || wb_stall !== 1'b0) begin
            err++;
            $display("FAIL r0_wb: got en=%b num=%0d data=%h mc_ready=%b stall=%b required 1 13 00000055 1 0",
                     rf_wr_en, rf_wr_num, rf_wr_data, mc_ready, wb_stall);
        end
        next_cyc();
        wb_valid = 0; wb_num = 0;
        mc_valid = 1; mc_num = 0; mc_data = 32'h77;
        iss_valid = 1; iss_num = 0; rd0_num = 0;
        push_wr(0, 0, 32'h77);
        @(negedge clk);
        e = exp_q.pop_front();
        vec++;
        if (rf_wr_en !== e.en || mc_ready !== 1'b1 || iss_ready !== 1'b1 || rd0_busy !== 1'b0) begin
            err++;
            $display("FAIL r0_mc_iss: got en=%b mc_ready=%b iss_ready=%b rd0_busy=%b required 0 1 1 0",
                     rf_wr_en, mc_ready, iss_ready, rd0_busy);
        end
        next_cyc();
        idle_inputs();
        rd0_num = 0; rd1_num = 13;
        #1;
        vec++;
        if (rd0_busy !== 1'b0 || rd1_busy !== 1'b0) begin
            err++;
            $display("FAIL r0_no_busy: got rd0_busy(r0)=%b rd1_busy(r13)=%b required 0 0", rd0_busy, rd1_busy);
        end
    endtask

    task automatic test_same_cycle();
        next_cyc();
        idle_inputs();
        iss_valid = 1; iss_num = 9; rd0_num = 9;
        @(negedge clk);
        vec++;
        if (iss_ready !== 1'b1) begin
            err++;
            $display("FAIL same_first_issue: iss_ready got %b required 1", iss_ready);
        end
        next_cyc();
        mc_valid = 1; mc_num = 9; mc_data = 32'h99;
        push_wr(1, 9, 32'h99);
        @(negedge clk);
        e = exp_q.pop_front();
        vec++;
        if (rf_wr_en !== e.en || rf_wr_num !== e.num || rf_wr_data !== e.data ||
            mc_ready !== 1'b1 || iss_ready !== 1'b0 || rd0_busy !== 1'b1) begin
            err++;
            $display("FAIL same_clear_issue: got en=%b num=%0d data=%h mc_ready=%b iss_ready=%b rd0_busy=%b required 1 9 00000099 1 0 1",
                     rf_wr_en, rf_wr_num, rf_wr_data, mc_ready, iss_ready, rd0_busy);
        end
        next_cyc();
        mc_valid = 0;
        @(negedge clk);
        vec++;
        if (iss_ready !== 1'b1 || rd0_busy !== 1'b0) begin
            err++;
            $display("FAIL same_reissue: got iss_ready=%b rd0_busy=%b required 1 0", iss_ready, rd0_busy);
        end
        next_cyc();
        iss_valid = 0;
        vec++;
        if (rd0_busy !== 1'b1) begin
            err++;
            $display("FAIL same_busy_set: rd0_busy got %b required 1", rd0_busy);
        end
    endtask

    task automatic test_reset_mid();
        next_cyc();
        idle_inputs();
        iss_valid = 1; iss_num = 3;
        @(negedge clk);
        vec++;
        if (iss_ready !== 1'b1) begin
            err++;
            $display("FAIL mid_issue_r3: iss_ready got %b required 1", iss_ready);
        end
        next_cyc();
        iss_num = 12;
        @(negedge clk);
        vec++;
        if (iss_ready !== 1'b1) begin
            err++;
            $display("FAIL mid_issue_r12: iss_ready got %b required 1", iss_ready);
        end
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            iss_valid = 0;
            wb_valid = 1; wb_num = 20; wb_data = 32'h2000 + k;
            mc_valid = 1; mc_num = 21; mc_data = 32'h2100;
            push_wr(1, 20, 32'h2000 + k);
            @(negedge clk);
            e = exp_q.pop_front();
            vec++;
            if (rf_wr_num !== e.num || rf_wr_data !== e.data || rf_wr_en !== e.en || mc_ready !== 1'b0) begin
                err++;
                $display("FAIL mid_refuse%0d: got en=%b num=%0d data=%h mc_ready=%b required 1 20 %h 0",
                         k, rf_wr_en, rf_wr_num, rf_wr_data, mc_ready, e.data);
            end
        end
        next_cyc();
        rd0_num = 3; rd1_num = 12;
        iss_valid = 1; iss_num = 5;
        #1;
        vec++;
        if (rd0_busy !== 1'b1 || rd1_busy !== 1'b1 || mc_ready !== 1'b0) begin
            err++;
            $display("FAIL mid_pre_reset: got b0=%b b1=%b mc_ready=%b required 1 1 0", rd0_busy, rd1_busy, mc_ready);
        end
        reset_n = 0;
        #1;
        vec++;
        if ({rf_wr_en, mc_ready, iss_ready, wb_stall, rd0_busy, rd1_busy} !== 6'b0) begin
            err++;
            $display("FAIL mid_in_reset: got en/mcr/issr/stall/b0/b1=%b required 000000",
                     {rf_wr_en, mc_ready, iss_ready, wb_stall, rd0_busy, rd1_busy});
        end
        iss_valid = 0;
        reset_n = 1;
        #1;
        vec++;
        if (rd0_busy !== 1'b0 || rd1_busy !== 1'b0) begin
            err++;
            $display("FAIL mid_busy_cleared: got rd0_busy(r3)=%b rd1_busy(r12)=%b required 0 0", rd0_busy, rd1_busy);
        end
        // Age must restart from zero: four more refusals before the mul/div result is taken.
        for (int j = 0; j < 5; j++) begin
            if (j > 0) next_cyc();
            wb_data = 32'h3000 + j;
            if (j == 4) push_wr(1, 21, 32'h2100);
            else        push_wr(1, 20, 32'h3000 + j);
            @(negedge clk);
            e = exp_q.pop_front();
            vec++;
            if (rf_wr_en !== e.en || rf_wr_num !== e.num || rf_wr_data !== e.data || mc_ready !== (j == 4)) begin
                err++;
                $display("FAIL mid_age_cycle%0d: got en=%b num=%0d data=%h mc_ready=%b required 1 %0d %h %b",
                         j, rf_wr_en, rf_wr_num, rf_wr_data, mc_ready, e.num, e.data, (j == 4));
            end
        end
        next_cyc();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset_n = 0;
        #2;
        test_reset();
        test_scoreboard();
        test_starvation();
        test_r0();
        test_same_cycle();
        test_reset_mid();
        vec++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL queue_drain: %0d expected writes left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Write-port arbiter and pending-write scoreboard for the 31-entry general-purpose register file (r1–r31; r0 reads as zero).
- Shares the single register-file write port between two sources: the pipeline writeback stage and the multi-cycle (mul/div) unit.
- Tracks which registers have a multi-cycle result outstanding, so the hazard unit can stall dependent reads.
- Includes a bounded-wait rule so the multi-cycle unit is never starved.

## Interface
Parameters:
- MAX_WAIT, 4, cycles a valid multi-cycle result may be refused before it takes priority over writeback (≥1).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback stage presents a write
- wb_num  in  5  writeback destination register
- wb_data  in  32  writeback data
- wb_stall  out  1  writeback refused this cycle; pipeline holds wb_* stable
- mc_valid  in  1  multi-cycle unit presents a result
- mc_num  in  5  multi-cycle destination register
- mc_data  in  32  multi-cycle result data
- mc_ready  out  1  multi-cycle result accepted this cycle
- iss_valid  in  1  multi-cycle op being issued
- iss_num  in  5  destination register of the issued op
- iss_ready  out  1  issue accepted; destination not already pending
- rd0_num, rd1_num  in  5 each  register numbers being read by decode
- rd0_busy, rd1_busy  out  1 each  that register has a pending multi-cycle write
- rf_wr_en  out  1  register-file write enable
- rf_wr_num  out  5  register-file write address
- rf_wr_data  out  32  register-file write data

## Operation
State:
- busy[31:1] scoreboard.
- age counter, width $clog2(MAX_WAIT+1).

Request qualification:
- A writeback request is wb_valid && wb_num≠0. A writeback with num 0 is consumed silently: no write, no stall.
- A multi-cycle request is mc_valid. A result with mc_num=0 still needs the port: it is accepted with rf_wr_en=0 and makes no scoreboard change.

Arbitration, evaluated every cycle:
- Writeback only: grant writeback, wb_stall=0.
- Multi-cycle only: grant multi-cycle, mc_ready=1.
- Both present and age<MAX_WAIT: writeback wins; mc_ready=0, wb_stall=0.
- Both present and age==MAX_WAIT: multi-cycle wins; mc_ready=1, wb_stall=1.
- Granted source drives rf_wr_num and rf_wr_data. rf_wr_en=1 only if the granted num≠0.

Age counter:
- Increments, saturating at MAX_WAIT, on each cycle with mc_valid && !mc_ready.
- Clears to 0 on a cycle with !mc_valid or mc_ready.

Scoreboard:
- Set: iss_valid && iss_ready && iss_num≠0 sets busy[iss_num].
- Clear: mc_valid && mc_ready && mc_num≠0 clears busy[mc_num].
- iss_ready = !busy[iss_num] (1 for iss_num=0). It is deliberately 0 while the same register is being cleared this cycle, so set and clear never hit the same bit in one cycle.
- rdX_busy = busy[rdX_num]; always 0 for r0. Bypass of the result being written this cycle is not provided.
- A multi-cycle write to a non-busy register is still performed; the scoreboard is unchanged.
- A writeback to a busy register is still performed; the scoreboard is unchanged. Preventing this WAW case is the hazard unit's job, using rdX_busy and iss_ready.

## Timing
- Grant path is combinational: rf_wr_* are valid in the same cycle as the request, and the register file captures them at the next rising edge.
- busy and age update on the rising clk edge.
- Scoreboard latency:
  - Issue in cycle N → rdX_busy high from N+1.
  - Accepted result in cycle M → rdX_busy low from M+1.
- Worst-case multi-cycle wait under continuous writeback: MAX_WAIT refused cycles, then acceptance on cycle MAX_WAIT+1.
- Reset, asserted (including mid-operation):
  - busy cleared to all zeros and age cleared to 0, immediately.
  - While reset_n is low: rf_wr_en=0, mc_ready=0, iss_ready=0, wb_stall=0, rdX_busy=0.
- Reset release: normal arbitration from the first rising edge after deassertion. Results in flight before reset are not written and leave no scoreboard state.

## Test plan
- Reset/idle: hold reset_n low with all valids high → rf_wr_en=0, mc_ready=0, iss_ready=0, all busy=0; release → writeback wb_num=5, wb_data=0x1234 is written the same cycle.
- Scoreboard: issue iss_num=7, then rd0_num=7 → rd0_busy=1 from next cycle; second issue to r7 gets iss_ready=0; mc result mc_num=7, data 0xCAFE → rf write r7=0xCAFE, rd0_busy=0 next cycle.
- Starvation bound (MAX_WAIT=4): continuous writeback plus mc_valid → mc_ready=0 for 4 cycles; on the 5th cycle mc_ready=1 and wb_stall=1; the next cycle writeback wins again and age=0.
- r0 handling: wb_num=0 with mc_valid → multi-cycle granted immediately, wb_stall=0; mc_num=0 → mc_ready=1, rf_wr_en=0, no busy change; iss_num=0 → iss_ready=1, no busy bit set.
- Same-cycle clear/issue: r9 busy, mc result to r9 accepted, and issue to r9 in the same cycle → iss_ready=0; next cycle re-issue to r9 → iss_ready=1 and busy[9]=1.
- Reset mid-operation: with r3 and r12 busy and age=3, pulse reset_n low asynchronously between edges → busy and age clear immediately; after release, rd0_num=3 reports rd0_busy=0.
